// File: rtl/data_line_mem.sv
// data_line_mem: line-granular data memory behind dcache_top with a fixed-latency ack.
// Optional out-of-range detection via DATA_LINE_MEM_RANGE_CHK_EN (adds err_o).
module data_line_mem #(
    parameter int LATENCY = 10,
    parameter int DEPTH   = 512
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
`ifdef DATA_LINE_MEM_RANGE_CHK_EN
    output logic         err_o,
`endif
    output logic [255:0] data_o
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [7:0] LOAD = 8'(LATENCY - 2);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic [IW-1:0]  r_idx;
    logic [255:0]   r_wdata;
    logic           r_we;
    logic           r_oor;
    logic           r_ack;
    logic           r_err;
    logic [255:0]   r_data;
    logic [255:0]   r_mem [DEPTH];

    logic [IW-1:0]  w_idx;
    logic           w_oor;
    logic           w_unused;

    assign w_idx = addr_i[5+IW-1:5];

`ifdef DATA_LINE_MEM_RANGE_CHK_EN
    assign w_oor    = |addr_i[31:5+IW];
    assign w_unused = ^addr_i[4:0];
    assign err_o    = r_err;
`else
    // Upper address bits alias onto the array when range checking is off.
    assign w_oor    = 1'b0;
    assign w_unused = ^{addr_i[4:0], addr_i[31:5+IW], r_err};
`endif

    assign ack_o  = r_ack;
    assign data_o = r_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (enable_i) begin
                        r_idx   <= w_idx;
                        r_wdata <= data_i;
                        r_we    <= write_i;
                        r_oor   <= w_oor;
                        r_cnt   <= LOAD;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_err   <= r_oor;
                        if (!r_we)
                            r_data <= r_oor ? '0 : r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Commit happens on the edge closing ACK; an async reset has already left ACK, so aborted writes never land.
    always_ff @(posedge clk_i) begin
        if (r_state == ACK && r_we && !r_oor)
            r_mem[r_idx] <= r_wdata;
    end
endmodule

// File: tb/tb_data_line_mem.sv
// tb_data_line_mem: scoreboard bench for data_line_mem with directed vectors.
module tb_data_line_mem;
    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  addr = '0;
    logic [255:0] din = '0;
    logic         en = 1'b0;
    logic         wr = 1'b0;
    logic         ack;
    logic         err;
    logic [255:0] dout;

    typedef struct {
        int           cyc;
        logic [255:0] data;
        logic         err;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    logic [255:0] last_rd = '0;

    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] P1 = {8{32'h1234_5678}};
    localparam logic [255:0] P2 = {16{16'hBEEF}};
    localparam logic [255:0] P3 = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] P4 = {32{8'h3C}};
    localparam logic [255:0] P5 = {8{32'hDEAD_0001}};
    localparam logic [255:0] P6 = {32{8'h77}};

    data_line_mem #(.LATENCY(LAT), .DEPTH(512)) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .addr_i(addr),
        .data_i(din),
        .enable_i(en),
        .write_i(wr),
        .ack_o(ack),
`ifdef DATA_LINE_MEM_RANGE_CHK_EN
        .err_o(err),
`endif
        .data_o(dout)
    );

`ifndef DATA_LINE_MEM_RANGE_CHK_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    // Monitor: every ack is matched against the oldest expected response.
    always @(negedge clk) begin
        if (rst_i && ack) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack actual_cycle=%0d required=none", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("ack_cycle", 256'(cyc), 256'(mon_e.cyc));
                chk("data_o", dout, mon_e.data);
                chk("err_o", 256'(err), 256'(mon_e.err));
            end
        end
    end

    task automatic push_exp(input int c, input logic w, input logic [255:0] exp_rd, input logic e);
        exp_t x;
        x.cyc  = c;
        x.data = w ? last_rd : exp_rd;
        x.err  = e;
        q.push_back(x);
        if (!w) last_rd = exp_rd;
    endtask

    task automatic issue(input logic [31:0] a, input logic [255:0] d, input logic w,
                         input logic [255:0] exp_rd, input logic e);
        @(negedge clk);
        addr = a;
        din  = d;
        wr   = w;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        push_exp(cyc - 1 + LAT, w, exp_rd, e);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (q.size() != 0 && n < 200);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout actual_pending=%0d required=0", q.size());
            q.delete();
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [255:0] d, input logic w,
                        input logic [255:0] exp_rd, input logic e);
        issue(a, d, w, exp_rd, e);
        wait_done();
    endtask

    initial begin
        int acc;
        #1 rst_i = 1'b0;
        #1;
        chk("reset_ack", 256'(ack), 256'(0));
        chk("reset_data", dout, '0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;

        xfer(32'h0000_0040, A5, 1'b1, '0, 1'b0);
        xfer(32'h0000_0040, '0, 1'b0, A5, 1'b0);

        xfer(32'h0000_0020, P1, 1'b1, '0, 1'b0);
        xfer(32'h0000_003F, '0, 1'b0, P1, 1'b0);

        xfer(32'h0000_0080, P2, 1'b1, '0, 1'b0);
        xfer(32'h0000_0100, P3, 1'b1, '0, 1'b0);
        issue(32'h0000_0080, '0, 1'b0, P2, 1'b0);
        @(negedge clk);
        addr = 32'h0000_0100;
        wr   = 1'b1;
        din  = {32{8'hEE}};
        wait_done();
        wr = 1'b0;
        xfer(32'h0000_0100, '0, 1'b0, P3, 1'b0);

        // Back-to-back: enable held through the first ACK.
        @(negedge clk);
        addr = 32'h0000_0040;
        wr   = 1'b0;
        en   = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc - 1;
        push_exp(acc + 10, 1'b0, A5, 1'b0);
        push_exp(acc + 21, 1'b0, A5, 1'b0);
        repeat (11) @(posedge clk);
        #1 en = 1'b0;
        wait_done();

        // Reset aborts an in-flight write.
        xfer(32'h0000_00C0, P4, 1'b1, '0, 1'b0);
        @(negedge clk);
        addr = 32'h0000_00C0;
        din  = 256'h1;
        wr   = 1'b1;
        en   = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_i = 1'b0;
        #1;
        chk("midreset_ack", 256'(ack), 256'(0));
        chk("midreset_data", dout, '0);
        @(negedge clk);
        rst_i   = 1'b1;
        wr      = 1'b0;
        last_rd = '0;
        repeat (2) @(negedge clk);
        xfer(32'h0000_00C0, '0, 1'b0, P4, 1'b0);

`ifdef DATA_LINE_MEM_RANGE_CHK_EN
        xfer(32'h0000_0000, P6, 1'b1, '0, 1'b0);
        xfer(32'h0001_0000, P5, 1'b1, '0, 1'b1);
        xfer(32'h0000_0000, '0, 1'b0, P6, 1'b0);
        xfer(32'h0001_0000, '0, 1'b0, '0, 1'b1);
`else
        xfer(32'h0001_0000, P5, 1'b1, '0, 1'b0);
        xfer(32'h0000_0000, '0, 1'b0, P5, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/data_line_mem.md
DATA_LINE_MEM -- requirements
Module: data_line_mem

Interface
REQ-001 Parameters SHALL be:
- LATENCY, default 10: cycles from request acceptance to ack; legal range 2..255.
- DEPTH, default 512: number of 256-bit lines; power of two.
REQ-002 Ports SHALL be, with the clock and reset first:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- addr_i  in  32  byte address of the request.
- data_i  in  256  write line data.
- enable_i  in  1  request valid, driven by dcache_top mem_enable_o.
- write_i  in  1  1=write, 0=read, driven by dcache_top mem_write_o.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  256  read line data.

Function
REQ-003 Role: the block SHALL be the line-granular data memory downstream of dcache_top, consuming its mem_* request and returning mem_ack/mem_data.
REQ-004 Line index SHALL be addr_i[5+log2(DEPTH)-1:5]; addr_i[4:0] SHALL be ignored.
REQ-005 The state machine SHALL have three states: IDLE, BUSY, ACK.
REQ-006 In IDLE, enable_i=1 SHALL accept the request: latch index, data_i and write_i, load counter with LATENCY-2, go to BUSY.
REQ-007 In BUSY, the counter SHALL decrement each cycle; at counter=0 the next state SHALL be ACK.
REQ-008 ack_o SHALL be 1 exactly during the ACK cycle, i.e. LATENCY cycles after the acceptance edge, and 0 otherwise.
REQ-009 Writes SHALL commit the latched line on the clock edge that ends the ACK cycle; no array write SHALL occur at any other time.
REQ-010 Reads: data_o SHALL present the array line at the latched index during the ACK cycle and SHALL hold that value until the next read ACK.
REQ-011 Write ACK SHALL leave data_o unchanged.
REQ-012 ACK SHALL always return to IDLE.
REQ-013 enable_i, addr_i, data_i and write_i SHALL be ignored in BUSY and ACK; changes after acceptance SHALL NOT affect the request in flight.
REQ-014 A request held high through ACK SHALL be re-accepted in the following IDLE cycle, giving back-to-back requests.
REQ-015 Array contents SHALL be unaffected by reset and uninitialised (X) until written.

Reset
REQ-016 rst_i=0 SHALL immediately force state=IDLE, counter=0, ack_o=0 and data_o=0, independent of clk_i.
REQ-017 Reset during BUSY or ACK SHALL abort the request, and a pending write SHALL NOT commit.
REQ-018 The first request SHALL be accepted on the first rising edge with rst_i=1 and enable_i=1.

Configuration
REQ-019 Macro DATA_LINE_MEM_RANGE_CHK_EN defined: the block SHALL add output port err_o (1 bit, reset 0) and flag latched addr_i[31:5+log2(DEPTH)] nonzero as out of range.
REQ-020 For an out-of-range request, the block SHALL still ack at normal latency and SHALL suppress the array write.
REQ-021 For an out-of-range request, the block SHALL drive data_o to all zeros on a read ACK.
REQ-022 For an out-of-range request, err_o SHALL pulse high coincident with ack_o.
REQ-023 Macro DATA_LINE_MEM_RANGE_CHK_EN undefined: err_o SHALL NOT exist, and upper address bits SHALL be ignored (aliasing).

Verification
REQ-024 Write then read, LATENCY=10: write addr 0x0000_0040 with data 256'hA5..A5, then read the same addr -> ack_o one cycle each, 10 cycles after acceptance; read data_o=256'hA5..A5.
REQ-025 Offset ignore: write 0x0000_0020, read 0x0000_003F -> same line returned.
REQ-026 Input change while BUSY: accept read of 0x80, then change addr_i to 0x100 and set write_i=1 during BUSY -> line 4 data returned; no write occurs.
REQ-027 Back-to-back: enable_i held high for 2 requests -> ack pulses at cycles 10 and 21, with one IDLE cycle between.
REQ-028 Reset mid-op: write 0xC0 with data 256'h1, assert rst_i at cycle 5 -> ack_o=0 and data_o=0 immediately; a later read of 0xC0 does not return 256'h1.
REQ-029 Range check, with DATA_LINE_MEM_RANGE_CHK_EN and DEPTH=512: write 0x0001_0000 -> ack_o and err_o pulse together; a later read of 0x0000_0000 is unaffected.
